// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that consumes DIGIT bits of each operand
// per clock through one ripple chain of DIGIT full-adder cells, with the
// carry held in a register between digits. A result takes WIDTH/DIGIT cycles.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into A - B (computed as A + ~B + 1; carry=1 means no borrow).
// WIDTH must be a multiple of DIGIT.
module serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             inCarry,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] part_reg;
   logic             cy_reg;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             done_reg;

   // Per-cell propagate/generate terms for the low digit of the operands.
   logic [DIGIT-1:0] prop;
   logic [DIGIT-1:0] gen;
   logic [DIGIT-1:0] digit_sum;
   logic             chain_out;

   // Operand B and the incoming carry as seen by the chain; subtraction
   // inverts B and forces a carry-in of one at capture time.
   logic [WIDTH-1:0] b_load;
   logic             cy_load;

   // Partial result: the new digit enters at the top and everything moves
   // down by DIGIT, so after N steps digit 0 sits at the LSB.
   logic [WIDTH+DIGIT-1:0] part_cat;
   logic [WIDTH-1:0]       part_next;

   genvar gi;
   generate
      for (gi = 0; gi < DIGIT; gi++) begin : g_cell
         assign prop[gi] = a_reg[gi] ^ b_reg[gi];
         assign gen[gi]  = a_reg[gi] & b_reg[gi];
      end
   endgenerate

   // Ripple the registered carry through the DIGIT full-adder cells.
   always_comb begin
      logic c;
      c         = cy_reg;
      digit_sum = '0;
      for (int i = 0; i < DIGIT; i++) begin
         digit_sum[i] = prop[i] ^ c;
         c            = gen[i] | (prop[i] & c);
      end
      chain_out = c;
   end

`ifdef SERIAL_ADDER_SUB_EN
   assign b_load  = sub ? ~inB : inB;
   assign cy_load = sub ? 1'b1 : inCarry;
`else
   assign b_load  = inB;
   assign cy_load = inCarry;
`endif

   assign part_cat  = {digit_sum, part_reg};
   assign part_next = part_cat[WIDTH+DIGIT-1:DIGIT];

   // Control FSM and datapath registers: capture in IDLE, one digit per RUN cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         part_reg  <= '0;
         cy_reg    <= 1'b0;
         count_reg <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg     <= inA;
                  b_reg     <= b_load;
                  cy_reg    <= cy_load;
                  part_reg  <= '0;
                  count_reg <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               a_reg     <= a_reg >> DIGIT;
               b_reg     <= b_reg >> DIGIT;
               part_reg  <= part_next;
               cy_reg    <= chain_out;
               count_reg <= count_reg + CW'(1);
               if (count_reg == LAST) begin
                  sum_reg   <= part_next;
                  carry_reg <= chain_out;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy  = (state_reg == RUN);
   assign done  = done_reg;
   assign sum   = sum_reg;
   assign carry = carry_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench for serial_adder with two instances,
// WIDTH=8/DIGIT=1 (8-cycle ops) and WIDTH=8/DIGIT=4 (2-cycle ops).
// Expected results are queued when an operation is started and popped
// when the instance raises done.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       reset;
   logic       start1;
   logic       start4;
   logic [7:0] inA;
   logic [7:0] inB;
   logic       inCarry;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub;
`endif

   logic       busy1, done1, carry1;
   logic [7:0] sum1;
   logic       busy4, done4, carry4;
   logic [7:0] sum4;

   int errors = 0;
   int checks = 0;

   logic [8:0] q1[$];
   logic [8:0] q4[$];

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
      .clk     (clk),
      .reset   (reset),
      .start   (start1),
`ifdef SERIAL_ADDER_SUB_EN
      .sub     (sub),
`endif
      .inA     (inA),
      .inB     (inB),
      .inCarry (inCarry),
      .busy    (busy1),
      .done    (done1),
      .sum     (sum1),
      .carry   (carry1)
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
      .clk     (clk),
      .reset   (reset),
      .start   (start4),
`ifdef SERIAL_ADDER_SUB_EN
      .sub     (sub),
`endif
      .inA     (inA),
      .inB     (inB),
      .inCarry (inCarry),
      .busy    (busy4),
      .done    (done4),
      .sum     (sum4),
      .carry   (carry4)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: 9-bit {carry, sum} of the 8-bit operation.
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic s);
      logic [7:0] nb;
      nb = ~b;
      if (s)
         return {1'b0, a} + {1'b0, nb} + 9'd1;
      return {1'b0, a} + {1'b0, b} + {8'd0, c};
   endfunction

   function automatic logic get_busy(input int which);
      return (which == 1) ? busy1 : busy4;
   endfunction
   function automatic logic get_done(input int which);
      return (which == 1) ? done1 : done4;
   endfunction
   function automatic logic get_carry(input int which);
      return (which == 1) ? carry1 : carry4;
   endfunction
   function automatic logic [7:0] get_sum(input int which);
      return (which == 1) ? sum1 : sum4;
   endfunction

   task automatic set_start(input int which, input logic v);
      if (which == 1) start1 = v;
      else start4 = v;
   endtask

   task automatic push_exp(input int which, input logic [8:0] e);
      if (which == 1) q1.push_back(e);
      else q4.push_back(e);
   endtask

   task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
      inA = a;
      inB = b;
      inCarry = c;
`ifdef SERIAL_ADDER_SUB_EN
      sub = s;
`else
      if (s) $display("note: subtract step requested in add-only build");
`endif
   endtask

   // Step until done (bounded), then check latency and the popped result.
   task automatic wait_done(input int which, input int lat, input int already,
                            output logic [8:0] e);
      int cyc;
      cyc = already;
      do begin
         step;
         cyc++;
      end while (!get_done(which) && cyc < 40);
      if (which == 1 && q1.size() > 0) e = q1.pop_front();
      else if (which == 4 && q4.size() > 0) e = q4.pop_front();
      else e = 'x;
      check("latency", cyc, lat);
      check("done_high", get_done(which), 1);
      check("busy_low_at_done", get_busy(which), 0);
      check("sum", get_sum(which), e[7:0]);
      check("carry", get_carry(which), e[8]);
      $display("dut%0d: op done after %0d cycles sum=%02h carry=%0d (exp %02h/%0d)",
               which, cyc, get_sum(which), get_carry(which), e[7:0], e[8]);
   endtask

   // One complete operation: accept, scramble inputs, wait, check pulse and hold.
   task automatic run_op(input int which, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic s, input int lat);
      logic [8:0] e;
      set_ops(a, b, c, s);
      push_exp(which, model(a, b, c, s));
      set_start(which, 1'b1);
      step;
      set_start(which, 1'b0);
      inA = ~a;
      inB = ~b;
      inCarry = ~c;
      check("busy_after_accept", get_busy(which), 1);
      wait_done(which, lat, 0, e);
      step;
      check("done_one_cycle", get_done(which), 0);
      check("sum_held", get_sum(which), e[7:0]);
      check("carry_held", get_carry(which), e[8]);
   endtask

   initial begin
      logic [8:0] e;
      int pulses;
      reset = 1'b1;
      start1 = 1'b0;
      start4 = 1'b0;
      set_ops(8'h00, 8'h00, 1'b0, 1'b0);
      step;
      step;
      reset = 1'b0;
      check("rst_busy1", busy1, 0);
      check("rst_done1", done1, 0);
      check("rst_sum1", sum1, 0);
      check("rst_carry1", carry1, 0);
      check("rst_busy4", busy4, 0);
      check("rst_done4", done4, 0);
      check("rst_sum4", sum4, 0);
      check("rst_carry4", carry4, 0);
      $display("reset: busy=%0d/%0d sum=%02h/%02h", busy1, busy4, sum1, sum4);
      step;

      // Basic add, overflow into carry, carry-in propagation.
      run_op(1, 8'h5A, 8'h33, 1'b0, 1'b0, 8);
      run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8);
      run_op(1, 8'hFF, 8'h00, 1'b1, 1'b0, 8);

      // Wide digit: two cycles per result.
      run_op(4, 8'h9C, 8'h75, 1'b1, 1'b0, 2);

      // Start during a run is ignored; start held in the done cycle is taken.
      set_ops(8'h3C, 8'h4B, 1'b0, 1'b0);
      push_exp(1, model(8'h3C, 8'h4B, 1'b0, 1'b0));
      start1 = 1'b1;
      step;
      start1 = 1'b0;
      step;
      step;
      set_ops(8'h01, 8'h01, 1'b0, 1'b0);
      start1 = 1'b1;
      step;
      start1 = 1'b0;
      wait_done(1, 8, 3, e);
      set_ops(8'h80, 8'h80, 1'b1, 1'b0);
      push_exp(1, model(8'h80, 8'h80, 1'b1, 1'b0));
      start1 = 1'b1;
      step;
      start1 = 1'b0;
      check("b2b_busy", busy1, 1);
      check("b2b_done_low", done1, 0);
      wait_done(1, 8, 0, e);
      step;

      // Reset in the middle of a run aborts it.
      set_ops(8'h12, 8'h34, 1'b0, 1'b0);
      start1 = 1'b1;
      step;
      start1 = 1'b0;
      step;
      step;
      step;
      reset = 1'b1;
      step;
      reset = 1'b0;
      check("abort_busy", busy1, 0);
      check("abort_done", done1, 0);
      check("abort_sum", sum1, 0);
      check("abort_carry", carry1, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step;
         if (done1) pulses++;
      end
      check("abort_no_done", pulses, 0);
      $display("abort: busy=%0d sum=%02h done pulses after reset=%0d", busy1, sum1, pulses);

      // A few random operations on each instance.
      for (int i = 0; i < 4; i++) begin
         run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'b0, 8);
         run_op(4, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'b0, 2);
      end

`ifdef SERIAL_ADDER_SUB_EN
      // Subtraction: carry-in is ignored, carry=1 means no borrow.
      run_op(1, 8'h10, 8'h01, 1'b0, 1'b1, 8);
      run_op(1, 8'h00, 8'h01, 1'b1, 1'b1, 8);
      run_op(4, 8'h10, 8'h01, 1'b1, 1'b1, 2);
      run_op(1, 8'h22, 8'h11, 1'b1, 1'b0, 8);
`endif

      check("queue1_drained", q1.size(), 0);
      check("queue4_drained", q4.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
